// File: rtl/rv_csr_exec.sv
// rv_csr_exec -- executes one RISC-V Zicsr instruction (CSRRW/RS/RC and the
// immediate forms) against an external CSR file, then hands the result to
// writeback.
//
// Sequence per instruction: IDLE (accept) -> READ (optional CSR load)
// -> WRITE (optional CSR store) -> RESP (hold result until out_ready).
//
// Ports
//   clock, reset        rising-edge clock; synchronous active-high reset
//   in_valid/in_ready   instruction handshake (ready only in IDLE)
//   funct3, csr, rs1,   instruction fields; rs1 doubles as zimm for the
//   rs1_value, rd       immediate forms
//   csr_addr            CSR address, held from READ through WRITE
//   csr_load            read strobe (READ only)
//   csr_store           write strobe (WRITE only) with csr_store_value
//   csr_sigill          CSR file access fault, combinational response
//   csr_load_value      CSR read data, combinational response
//   out_valid/out_ready result handshake to writeback
//   out_rd, out_value,  destination index, old CSR value, illegal flag
//   out_sigill
//
// Parameter rv64: 1 = 64-bit datapath, 0 = 32-bit datapath.
// Optional macro RV_CSR_EXEC_RO_CHECK_EN: writes to read-only CSRs
// (csr[11:10] == 2'b11) trap in READ without touching the CSR file.

module rv_csr_exec #(
  parameter int rv64 = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    funct3,
  input  logic [11:0]                   csr,
  input  logic [4:0]                    rs1,
  input  logic [(rv64 ? 64 : 32)-1:0]   rs1_value,
  input  logic [4:0]                    rd,
  output logic [11:0]                   csr_addr,
  output logic                          csr_load,
  output logic                          csr_store,
  output logic [(rv64 ? 64 : 32)-1:0]   csr_store_value,
  input  logic                          csr_sigill,
  input  logic [(rv64 ? 64 : 32)-1:0]   csr_load_value,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [4:0]                    out_rd,
  output logic [(rv64 ? 64 : 32)-1:0]   out_value,
  output logic                          out_sigill
);

  localparam int xlen = rv64 ? 64 : 32;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t            state, state_next;
  logic [2:0]        op_funct3;
  logic [11:0]       op_csr;
  logic [4:0]        op_rs1;
  logic [4:0]        op_rd;
  logic [xlen-1:0]   op_src;
  logic [xlen-1:0]   old_value;
  logic              read_done;
  logic              sigill_q;

  logic              accept;
  logic              op_illegal;
  logic              read_needed;
  logic              write_needed;
  logic              ro_block;
  logic              read_sigill;

  assign accept   = in_valid && in_ready;
  assign csr_addr = op_csr;

  // Decode of the captured instruction. funct3[1:0] selects RW/RS/RC; 00 is
  // not a CSR op at all. The write test uses the rs1 index / zimm field, not
  // the register value, so CSRRS x0-style reads never store.
  assign op_illegal   = (op_funct3[1:0] == 2'b00);
  assign read_needed  = (op_funct3[1:0] != 2'b01) || (op_rd != 5'd0);
  assign write_needed = (op_funct3[1:0] == 2'b01) || (op_rs1 != 5'd0);

`ifdef RV_CSR_EXEC_RO_CHECK_EN
  assign ro_block = !op_illegal && write_needed && (op_csr[11:10] == 2'b11);
`else
  assign ro_block = 1'b0;
`endif

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next      = state;
    in_ready        = 1'b0;
    csr_load        = 1'b0;
    csr_store       = 1'b0;
    csr_store_value = '0;
    out_valid       = 1'b0;
    out_rd          = 5'd0;
    out_value       = '0;
    out_sigill      = 1'b0;
    read_sigill     = 1'b0;

    // Reset is synchronous, so outputs are gated here to stay quiet for the
    // whole reset cycle, including an in-flight store being abandoned.
    if (!reset) begin
      unique case (state)
        IDLE: begin
          in_ready = 1'b1;
          if (in_valid) state_next = READ;
        end
        READ: begin
          csr_load    = !op_illegal && read_needed && !ro_block;
          read_sigill = op_illegal || ro_block || (csr_load && csr_sigill);
          state_next  = (!op_illegal && write_needed && !read_sigill) ? WRITE : RESP;
        end
        WRITE: begin
          csr_store = 1'b1;
          unique case (op_funct3[1:0])
            2'b01:   csr_store_value = op_src;
            2'b10:   csr_store_value = old_value | op_src;
            default: csr_store_value = old_value & ~op_src;
          endcase
          state_next = RESP;
        end
        RESP: begin
          out_valid  = 1'b1;
          out_sigill = sigill_q;
          out_rd     = sigill_q ? 5'd0 : op_rd;
          out_value  = (read_done && !sigill_q) ? old_value : '0;
          if (out_ready) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      op_funct3 <= 3'd0;
      op_csr    <= 12'd0;
      op_rs1    <= 5'd0;
      op_rd     <= 5'd0;
      op_src    <= '0;
      old_value <= '0;
      read_done <= 1'b0;
      sigill_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_funct3 <= funct3;
        op_csr    <= csr;
        op_rs1    <= rs1;
        op_rd     <= rd;
        op_src    <= funct3[2] ? {{(xlen-5){1'b0}}, rs1} : rs1_value;
        old_value <= '0;
        read_done <= 1'b0;
        sigill_q  <= 1'b0;
      end
      if (state == READ) begin
        read_done <= csr_load;
        sigill_q  <= read_sigill;
        if (csr_load) old_value <= csr_load_value;
      end
      if (state == WRITE && csr_sigill) sigill_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rv_csr_exec.sv
// Self-checking bench for rv_csr_exec (rv64 = 1). A small CSR-file model
// answers loads with a per-vector old value and raises csr_sigill on load or
// store as each vector requests. The expected behaviour of each instruction
// is derived from the CSR instruction rules and checked every cycle.

module tb_rv_csr_exec;

  localparam int XLEN = 64;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        funct3;
  logic [11:0]       csr;
  logic [4:0]        rs1;
  logic [XLEN-1:0]   rs1_value;
  logic [4:0]        rd;
  logic [11:0]       csr_addr;
  logic              csr_load;
  logic              csr_store;
  logic [XLEN-1:0]   csr_store_value;
  logic              csr_sigill;
  logic [XLEN-1:0]   csr_load_value;
  logic              out_valid;
  logic              out_ready;
  logic [4:0]        out_rd;
  logic [XLEN-1:0]   out_value;
  logic              out_sigill;

  rv_csr_exec #(.rv64(1)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .csr(csr), .rs1(rs1), .rs1_value(rs1_value), .rd(rd),
    .csr_addr(csr_addr), .csr_load(csr_load), .csr_store(csr_store),
    .csr_store_value(csr_store_value), .csr_sigill(csr_sigill),
    .csr_load_value(csr_load_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_value(out_value), .out_sigill(out_sigill)
  );

  always #5 clock = ~clock;

  // CSR file model
  logic [XLEN-1:0] file_old;
  logic            sig_on_load, sig_on_store;
  assign csr_load_value = file_old;
  assign csr_sigill     = (csr_load && sig_on_load) || (csr_store && sig_on_store);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected behaviour of the current instruction
  bit              active = 1'b0;
  int              cyc = 0;
  int              acc_cyc = 0;
  bit              m_load, m_write, m_sig;
  logic [XLEN-1:0] m_sv, m_val;
  logic [4:0]      m_rd;
  logic [11:0]     m_csr;
  int              m_resp_rel;
  int              store_cnt = 0;
  int              exp_store_cnt = 0;

  always @(posedge clock) begin
    cyc++;
    if (csr_store) store_cnt++;
  end

  // Per-cycle comparison against the expected timeline: READ is the cycle
  // after accept (rel 0), the store (if any) follows, then RESP holds.
  always @(negedge clock) begin
    int rel;
    bit e_ready, e_valid, e_load, e_store, e_sig;
    logic [XLEN-1:0] e_sv, e_val;
    logic [4:0] e_rd;
    rel = cyc - acc_cyc;
    e_ready = 0; e_valid = 0; e_load = 0; e_store = 0; e_sig = 0;
    e_sv = '0; e_val = '0; e_rd = '0;
    if (reset) begin
      e_ready = 0;
    end else if (!active) begin
      e_ready = 1;
    end else if (rel >= m_resp_rel) begin
      e_valid = 1; e_sig = m_sig; e_rd = m_rd; e_val = m_val;
    end else if (rel == 0) begin
      e_load = m_load;
      check("csr_addr_read", csr_addr, m_csr);
    end else begin
      e_store = 1; e_sv = m_sv;
      check("csr_addr_write", csr_addr, m_csr);
      check("store_value", csr_store_value, e_sv);
    end
    check("in_ready", in_ready, e_ready);
    check("out_valid", out_valid, e_valid);
    check("csr_load", csr_load, e_load);
    check("csr_store", csr_store, e_store);
    check("out_sigill", out_sigill, e_sig);
    check("out_rd", out_rd, e_rd);
    check("out_value", out_value, e_val);
  end

  typedef struct {
    logic [2:0]      f3;
    logic [11:0]     csr;
    logic [4:0]      rs1;
    logic [XLEN-1:0] rs1v;
    logic [4:0]      rd;
    logic [XLEN-1:0] old;
    bit              sl;
    bit              ss;
    int              stall;
    logic [XLEN-1:0] hval;
    logic [4:0]      hrd;
    bit              hsig;
    logic [XLEN-1:0] hsv;
  } vec_t;

  // Derive the expected behaviour from the CSR instruction rules.
  task automatic build_model(input vec_t v);
    bit illegal, rd_need, wr_need, ro, load_sig, ro_en;
    logic [XLEN-1:0] src;
`ifdef RV_CSR_EXEC_RO_CHECK_EN
    ro_en = 1'b1;
`else
    ro_en = 1'b0;
`endif
    illegal  = (v.f3 == 3'b000) || (v.f3 == 3'b100);
    src      = v.f3[2] ? XLEN'(v.rs1) : v.rs1v;
    rd_need  = !illegal && ((v.f3[1:0] != 2'b01) || (v.rd != 0));
    wr_need  = !illegal && ((v.f3[1:0] == 2'b01) || (v.rs1 != 0));
    ro       = ro_en && wr_need && (v.csr[11:10] == 2'b11);
    m_load   = rd_need && !ro;
    load_sig = m_load && v.sl;
    m_write  = wr_need && !ro && !load_sig;
    case (v.f3[1:0])
      2'b01:   m_sv = src;
      2'b10:   m_sv = v.old | src;
      default: m_sv = v.old & ~src;
    endcase
    m_sig      = illegal || ro || load_sig || (m_write && v.ss);
    m_val      = (m_load && !m_sig) ? v.old : '0;
    m_rd       = m_sig ? 5'd0 : v.rd;
    m_csr      = v.csr;
    m_resp_rel = m_write ? 2 : 1;
  endtask

  task automatic present(input vec_t v);
    funct3 = v.f3; csr = v.csr; rs1 = v.rs1; rs1_value = v.rs1v; rd = v.rd;
    file_old = v.old; sig_on_load = v.sl; sig_on_store = v.ss;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    acc_cyc = cyc;
    active = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    build_model(v);
    check("model_value", m_val, v.hval);
    check("model_rd", m_rd, v.hrd);
    check("model_sigill", m_sig, v.hsig);
    if (m_write) check("model_store_value", m_sv, v.hsv);
    if (m_write) exp_store_cnt++;
    present(v);
    repeat (m_resp_rel + v.stall) begin
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    active = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    int base_stores;
    vec_t rv;
    //           f3      csr     rs1    rs1v                    rd     old          sl ss st hval     hrd    hsig hsv
    vecs[0] = '{3'b010, 12'hC00, 5'd0,  64'hDEAD,               5'd5, 64'h1234,    0, 0, 0, 64'h1234, 5'd5, 0, 64'h0};
    vecs[1] = '{3'b011, 12'h341, 5'd3,  64'hF0,                 5'd7, 64'hFF,      0, 0, 0, 64'hFF,   5'd7, 0, 64'h0F};
    vecs[2] = '{3'b101, 12'h340, 5'h1F, 64'h0,                  5'd0, 64'hAAAA,    0, 0, 0, 64'h0,    5'd0, 0, 64'h1F};
    vecs[3] = '{3'b001, 12'hC01, 5'd2,  64'h55,                 5'd4, 64'h77,      0, 1, 0, 64'h0,    5'd0, 1, 64'h55};
    vecs[4] = '{3'b100, 12'h300, 5'd3,  64'h9,                  5'd9, 64'h44,      0, 0, 0, 64'h0,    5'd0, 1, 64'h0};
    vecs[5] = '{3'b110, 12'h300, 5'h0A, 64'h0,                  5'd1, 64'h100,     0, 0, 4, 64'h100,  5'd1, 0, 64'h10A};
    vecs[6] = '{3'b001, 12'h305, 5'd6,  64'h123456789ABCDEF0,   5'd0, 64'h3,       0, 0, 0, 64'h0,    5'd0, 0, 64'h123456789ABCDEF0};
    vecs[7] = '{3'b111, 12'h340, 5'd0,  64'h0,                  5'd3, 64'h5A,      0, 0, 0, 64'h5A,   5'd3, 0, 64'h0};
    vecs[8] = '{3'b010, 12'h344, 5'd1,  64'h1,                  5'd2, 64'h66,      1, 0, 0, 64'h0,    5'd0, 1, 64'h0};
    vecs[9] = '{3'b000, 12'h300, 5'd1,  64'h1,                  5'd6, 64'h66,      0, 0, 1, 64'h0,    5'd0, 1, 64'h0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    funct3 = '0; csr = '0; rs1 = '0; rs1_value = '0; rd = '0;
    file_old = '0; sig_on_load = 1'b0; sig_on_store = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while the store is pending: no store, back to IDLE next cycle.
    rv = '{3'b001, 12'h340, 5'd1, 64'hBEEF, 5'd1, 64'h11, 0, 0, 0, 64'h11, 5'd1, 0, 64'hBEEF};
    build_model(rv);
    check("model_reset_write", m_write, 1'b1);
    base_stores = store_cnt;
    present(rv);
    @(posedge clock); #1;
    reset = 1'b1;
    active = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    check("no_store_on_reset", store_cnt, base_stores);

    // A normal op after the abandoned one still works.
    run_vec(vecs[1]);
    check("total_stores", store_cnt, exp_store_cnt);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rv_csr_exec.md
RV_CSR_EXEC -- requirements
Module: rv_csr_exec

Interface
REQ-001 SHALL have parameter: rv64, default 1, 1 = RV64 (xlen 64), 0 = RV32 (xlen 32).
REQ-002 SHALL have port: clock  input  1  clock; all state on rising edge.
REQ-003 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  CSR instruction offered.
REQ-005 SHALL have port: in_ready  output  1  block accepts instruction.
REQ-006 SHALL have port: funct3  input  3  CSR op (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI).
REQ-007 SHALL have port: csr  input  12  CSR address.
REQ-008 SHALL have port: rs1  input  5  rs1 index / zimm.
REQ-009 SHALL have port: rs1_value  input  xlen  rs1 register value.
REQ-010 SHALL have port: rd  input  5  destination index.
REQ-011 SHALL have ports: csr_addr output 12, csr_load output 1, csr_store output 1, csr_store_value output xlen, csr_sigill input 1, csr_load_value input xlen; these connect to the CSR file, whose load/sigill response is combinational in the same cycle.
REQ-012 SHALL have ports: out_valid output 1, out_ready input 1, out_rd output 5, out_value output xlen, out_sigill output 1; result to writeback.

Function
REQ-013 SHALL sample funct3, csr, rs1, rs1_value, rd on the cycle in_valid && in_ready; in_ready = 1 only in IDLE.
REQ-014 SHALL implement states IDLE, READ, WRITE, RESP.
REQ-015 Transitions SHALL be: IDLE->READ on accept; READ->WRITE if write needed and no sigill, else READ->RESP; WRITE->RESP; RESP->IDLE when out_ready.
REQ-016 Source SHALL be rs1_value for funct3[2]=0, else {(xlen-5) zeros, rs1}.
REQ-017 Read needed SHALL be: always for RS/RC/RSI/RCI; for RW/RWI only when rd != 0.
REQ-018 Write needed SHALL be: always for RW/RWI; for RS/RC/RSI/RCI only when rs1 != 0 (index or zimm, regardless of rs1_value).
REQ-019 In READ, csr_load SHALL equal read needed; csr_load_value captured as old; csr_sigill captured.
REQ-020 In WRITE, csr_store SHALL be 1 with csr_store_value = src (RW*), old | src (RS*), old & ~src (RC*); csr_sigill captured.
REQ-021 csr_load and csr_store SHALL be 0 in all other states; csr_addr SHALL hold the captured csr from READ through WRITE.
REQ-022 funct3 000 or 100 SHALL produce out_sigill=1 with no csr_load/csr_store asserted (READ passes straight to RESP).
REQ-023 In RESP, out_valid=1, out_rd = captured rd, out_value = old if read performed and no sigill, else 0; outputs held stable until out_ready.
REQ-024 Latency: accept at cycle N -> out_valid at N+2 (no write) or N+3 (write); throughput one instruction per completed RESP handshake.
REQ-025 out_rd SHALL be forced to 0 when out_sigill=1.

Reset
REQ-026 reset SHALL force state IDLE in the cycle it is sampled, abandoning any in-flight op without a store.
REQ-027 While reset asserted: in_ready=0, out_valid=0, csr_load=0, csr_store=0, out_sigill=0, out_value=0, out_rd=0; after release in_ready=1.

Configuration
REQ-028 Macro RV_CSR_EXEC_RO_CHECK_EN: when defined, a write needed to csr[11:10]==2'b11 SHALL set out_sigill in READ, skip WRITE, and never assert csr_store, with csr_load also suppressed.
REQ-029 Without RV_CSR_EXEC_RO_CHECK_EN, such writes SHALL proceed to WRITE and sigill SHALL come only from csr_sigill.

Verification
REQ-030 CSRRS rd=5 rs1=0 csr=0xC00, csr_load_value=0x1234 -> no store; out_valid at N+2; out_value=0x1234; out_rd=5.
REQ-031 CSRRC rs1=3 value 0xF0, old=0xFF -> csr_store at N+2 with 0x0F; out_value=0xFF at N+3.
REQ-032 CSRRWI rd=0 zimm=0x1F -> csr_load never asserted; store value 0x1F; out_value=0.
REQ-033 CSRRW to 0xC01 with csr_sigill=1 on store -> out_sigill=1, out_rd=0; with RV_CSR_EXEC_RO_CHECK_EN, no csr_store.
REQ-034 funct3=100 -> out_sigill=1 at N+2, csr_load=csr_store=0 throughout.
REQ-035 out_ready=0 for 4 cycles in RESP then 1 -> outputs stable, in_ready=0 until handshake; reset asserted in WRITE -> no store, IDLE next cycle.
